// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first requester after ptr wins, ptr itself searched last.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NREQ-1:0]  win_oh,
  output logic [SEL_W-1:0] win_idx,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    win_oh = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        win_oh[cand] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign win_idx = onehot_to_idx(win_oh);
  assign any     = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 word mux and result register among four requesters.
// state | meaning
// IDLE  | no grant; arbitrate among req on the next edge
// GRANT | one requester owns the mux until last, burst limit, or req drop
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  last,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  ack,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [WIDTH-1:0] mux_word;
  logic [NREQ-1:0]  win_oh;
  logic [SEL_W-1:0] win_idx;
  logic             win_any;
  logic             accept;
  logic             burst_end;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  always_comb begin
    mux_word = d0;
    case (sel)
      2'd0: mux_word = d0;
      2'd1: mux_word = d1;
      2'd2: mux_word = d2;
      2'd3: mux_word = d3;
      default: mux_word = d0;
    endcase
  end

  // A held word blocks the granted requester until downstream takes it.
  assign accept    = (state == GRANT) && req[sel] && (!out_valid || out_ready);
  assign ack       = accept ? gnt : '0;
  assign en        = accept;
  assign burst_end = accept && (last[sel] || (beat_cnt == CNT_LAST));
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      ptr       <= SEL_W'(NREQ - 1);
      beat_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            gnt      <= win_oh;
            sel      <= win_idx;
            ptr      <= win_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!req[sel] || burst_end) begin
            gnt   <= '0;
            state <= IDLE;
          end
          if (accept) beat_cnt <= beat_cnt + CNT_ONE;
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase

      if (accept) begin
        out_data  <= mux_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized bench for mux_rr_arbiter: behavioural model feeds a word scoreboard.
module tb_mux_rr_arbiter;

  localparam int WIDTH = 32;
  localparam int MB    = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0]       req, last;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic             out_ready;
  logic [3:0]       gnt, ack;
  logic [1:0]       sel;
  logic             en, out_valid, busy;
  logic [WIDTH-1:0] out_data;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MB)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .gnt       (gnt),
    .ack       (ack),
    .sel       (sel),
    .en        (en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];

  // model state: cur = granted requester or -1, mptr = last granted index
  int  cur, mptr, beats;
  bit  mv, after_rst, flush_pending, checking;
  logic [3:0] exp_gnt, exp_ack;
  bit  exp_busy, exp_valid, exp_zero;
  int  exp_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    cur   = -1;
    mptr  = 3;
    beats = 0;
    mv    = 1'b0;
  endtask

  task automatic eval_cycle();
    logic [WIDTH-1:0] dv[4];
    bit acc, found;
    int idx;
    dv        = '{d0, d1, d2, d3};
    exp_gnt   = (cur < 0) ? 4'b0 : 4'(1 << cur);
    exp_busy  = (cur >= 0);
    exp_valid = mv;
    exp_sel   = cur;
    exp_zero  = after_rst;
    after_rst = reset;
    acc       = (cur >= 0) && req[cur] && (!mv || out_ready);
    exp_ack   = acc ? exp_gnt : 4'b0;
    if (acc) q.push_back(dv[cur]);
    if (reset) begin
      model_reset();
      flush_pending = 1'b1;
      return;
    end
    if (cur < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        idx = (mptr + k) % 4;
        if (!found && req[idx]) begin
          found = 1'b1;
          cur   = idx;
          mptr  = idx;
          beats = 0;
        end
      end
    end else if (!req[cur]) begin
      cur = -1;
    end else if (acc) begin
      beats++;
      if (last[cur] || beats == MB) cur = -1;
    end
    if (acc) mv = 1'b1;
    else if (out_ready) mv = 1'b0;
  endtask

  always @(negedge clock) begin
    if (checking) begin
      check("gnt", gnt, exp_gnt);
      check("ack", ack, exp_ack);
      check("en", en, |exp_ack);
      check("busy", busy, exp_busy);
      check("out_valid", out_valid, exp_valid);
      if (exp_sel >= 0) check("sel", sel, exp_sel);
      if (exp_zero) check("out_data_rst", out_data, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty actual=%h expected=no_word t=%0t", out_data, $time);
        end else begin
          check("out_data", out_data, q.pop_front());
        end
      end
    end
  end

  initial begin
    int phase;
    reset = 1'b1; req = '0; last = '0; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    checking = 1'b0; flush_pending = 1'b0; after_rst = 1'b1;
    model_reset();
    for (int n = 0; n < 1600; n++) begin
      @(posedge clock);
      if (flush_pending) begin
        q.delete();
        flush_pending = 1'b0;
      end
      #1;
      phase = n / 400;
      d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
      case (phase)
        0: begin
          req = 4'hF; last = 4'hF; out_ready = 1'b1;
        end
        1: begin
          req = 4'b0100 | (($urandom_range(0, 3) == 0) ? (4'($urandom) & 4'b1011) : 4'b0000);
          last = 4'b0000; out_ready = 1'b1;
        end
        2: begin
          req = 4'($urandom);
          last = 4'($urandom) & 4'($urandom);
          out_ready = ($urandom_range(0, 9) >= 4);
        end
        default: begin
          for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 9) < 8);
          for (int b = 0; b < 4; b++) last[b] = ($urandom_range(0, 9) == 0);
          out_ready = ($urandom_range(0, 9) < 7);
        end
      endcase
      reset = (n < 2) || (phase >= 2 && $urandom_range(0, 99) == 0);
      checking = 1'b1;
      eval_cycle();
    end
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
